zbus_master: RTL and testbench

Initiator end of the ZX-bus. Executes single Z80-style memory and IO read/write cycles on `za`/`zd`/`zmreq_n`/`ziorq_n`/`zrd_n`/`zwr_n` on behalf of an internal request port. Honours `zwait_n` and reports whether a card claimed an IO cycle via `ziorqge`. It drives the same bus the card-side decoder responds to, and is used for bench bring-up of the ZXiznet card and for host-side test rigs.

---
 rtl/zbus_pkg.sv | 32 +++
 rtl/zbus_tstate_tick.sv | 29 ++
 rtl/zbus_master.sv | 169 ++++++++++++++++
 tb/tb_zbus_master.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zbus_pkg.sv
// Shared types for the ZX-bus initiator: bus-cycle FSM states and the
// four Z80 cycle kinds, with helpers that decode a cycle kind into its strobes.
package zbus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_TW   = 3'd3,
    ST_T3   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    MEMRD = 2'b00,
    MEMWR = 2'b01,
    IORD  = 2'b10,
    IOWR  = 2'b11
  } cyc_t;

  function automatic cyc_t cycType(input logic io, input logic we);
    return cyc_t'({io, we});
  endfunction

  function automatic logic isIo(input cyc_t c);
    return (c == IORD) || (c == IOWR);
  endfunction

  function automatic logic isWrite(input cyc_t c);
    return (c == MEMWR) || (c == IOWR);
  endfunction

endpackage

// File: rtl/zbus_tstate_tick.sv
// T-state timer: counts T_CLKS clocks per T-state and flags the last clock.
// Held at reload while the FSM idles so T1 starts with a full T-state.
module zbus_tstate_tick #(
  parameter int T_CLKS = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  output logic o_last
);

  localparam int CW = (T_CLKS > 1) ? $clog2(T_CLKS) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(T_CLKS - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= RELOAD;
    end else if (i_load || (r_cnt == '0)) begin
      r_cnt <= RELOAD;
    end else begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_last = (r_cnt == '0);

endmodule

// File: rtl/zbus_master.sv
// ZX-bus initiator: runs one Z80-style memory/IO read or write cycle per
// request, stretching it for automatic IO waits and card-driven zwait_n.
module zbus_master
  import zbus_pkg::*;
#(
  parameter int T_CLKS   = 2,
  parameter int IO_WAIT  = 1,
  parameter int WAIT_MAX = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic        io,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic        busy,
  output logic        ack,
  output logic [7:0]  rdata,
  output logic        claimed,
  output logic        err,
  output logic [15:0] za,
  output logic [7:0]  zd_out,
  output logic        zd_oe,
  input  logic [7:0]  zd_in,
  output logic        zmreq_n,
  output logic        ziorq_n,
  output logic        zrd_n,
  output logic        zwr_n,
  input  logic        zwait_n,
  input  logic        ziorqge
);

  localparam logic [1:0] IO_WAIT_L  = 2'(IO_WAIT);
  localparam logic [7:0] WAIT_MAX_L = 8'(WAIT_MAX);

  state_t      r_state, w_stateNxt;
  cyc_t        r_cyc, w_cycNxt;
  logic        w_last, w_tickLoad, w_accept, w_endT3;
  logic        w_autoTw, w_extraTw, w_abort, w_strobe;
  logic [1:0]  r_autoCnt;
  logic [7:0]  r_waitCnt;
  logic        r_errPend;
  logic        r_busy, r_ack, r_mreqN, r_iorqN, r_rdN, r_wrN, r_zdOe;
  logic        w_busy, w_mreqN, w_iorqN, w_rdN, w_wrN, w_zdOe;
  logic [15:0] r_za;
  logic [7:0]  r_zdOut, r_rdata;
  logic        r_claimed, r_err;

  assign w_tickLoad = (r_state == ST_IDLE);
  assign w_accept   = (r_state == ST_IDLE) && req;
  assign w_endT3    = (r_state == ST_T3) && w_last;

  zbus_tstate_tick #(.T_CLKS(T_CLKS)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_tickLoad),
    .o_last (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_ack   <= 1'b0;
      r_mreqN <= 1'b1;
      r_iorqN <= 1'b1;
      r_rdN   <= 1'b1;
      r_wrN   <= 1'b1;
      r_zdOe  <= 1'b0;
    end else begin
      r_state <= w_stateNxt;
      r_busy  <= w_busy;
      r_ack   <= w_endT3;
      r_mreqN <= w_mreqN;
      r_iorqN <= w_iorqN;
      r_rdN   <= w_rdN;
      r_wrN   <= w_wrN;
      r_zdOe  <= w_zdOe;
    end
  end

  // Automatic IO waits are spent before zwait_n is even looked at.
  always_comb begin
    w_stateNxt = r_state;
    w_autoTw   = 1'b0;
    w_extraTw  = 1'b0;
    w_abort    = 1'b0;
    case (r_state)
      ST_IDLE: if (req) w_stateNxt = ST_T1;
      ST_T1:   if (w_last) w_stateNxt = ST_T2;
      ST_T2, ST_TW: begin
        if (w_last) begin
          if (isIo(r_cyc) && (r_autoCnt < IO_WAIT_L)) begin
            w_stateNxt = ST_TW;
            w_autoTw   = 1'b1;
          end else if (!zwait_n && (r_waitCnt < WAIT_MAX_L)) begin
            w_stateNxt = ST_TW;
            w_extraTw  = 1'b1;
          end else if (!zwait_n) begin
            w_stateNxt = ST_T3;
            w_abort    = 1'b1;
          end else begin
            w_stateNxt = ST_T3;
          end
        end
      end
      ST_T3:   if (w_last) w_stateNxt = ST_IDLE;
      default: w_stateNxt = ST_IDLE;
    endcase
  end

  // Decoded from the next state so the registered strobes switch exactly on T-state boundaries.
  always_comb begin
    w_cycNxt = w_accept ? cycType(io, we) : r_cyc;
    w_strobe = (w_stateNxt == ST_T2) || (w_stateNxt == ST_TW) || (w_stateNxt == ST_T3);
    w_mreqN  = !(w_strobe && !isIo(w_cycNxt));
    w_iorqN  = !(w_strobe && isIo(w_cycNxt));
    w_rdN    = !(w_strobe && !isWrite(w_cycNxt));
    w_wrN    = !(w_strobe && isWrite(w_cycNxt));
    w_zdOe   = (w_stateNxt != ST_IDLE) && isWrite(w_cycNxt);
    w_busy   = (w_stateNxt != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cyc     <= MEMRD;
      r_za      <= '0;
      r_zdOut   <= '0;
      r_autoCnt <= '0;
      r_waitCnt <= '0;
      r_errPend <= 1'b0;
      r_rdata   <= '0;
      r_claimed <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cyc     <= cycType(io, we);
        r_za      <= addr;
        r_zdOut   <= wdata;
        r_autoCnt <= '0;
        r_waitCnt <= '0;
        r_errPend <= 1'b0;
      end
      if (w_autoTw)  r_autoCnt <= r_autoCnt + 2'd1;
      if (w_extraTw) r_waitCnt <= r_waitCnt + 8'd1;
      if (w_abort)   r_errPend <= 1'b1;
      if (w_endT3) begin
        if (!isWrite(r_cyc)) r_rdata <= zd_in;
        r_claimed <= isIo(r_cyc) && ziorqge;
        r_err     <= r_errPend;
      end
    end
  end

  assign busy    = r_busy;
  assign ack     = r_ack;
  assign rdata   = r_rdata;
  assign claimed = r_claimed;
  assign err     = r_err;
  assign za      = r_za;
  assign zd_out  = r_zdOut;
  assign zd_oe   = r_zdOe;
  assign zmreq_n = r_mreqN;
  assign ziorq_n = r_iorqN;
  assign zrd_n   = r_rdN;
  assign zwr_n   = r_wrN;

endmodule

// File: tb/tb_zbus_master.sv
// Bench for zbus_master: each transaction's waveform is predicted from cycle
// arithmetic (T-state counts, wait budget) and compared on every clock.
module tb_zbus_master;

  localparam int TC   = 2;
  localparam int IOW  = 1;
  localparam int WMAX = 3;

  logic        clk = 1'b0;
  logic        rst, req, we, io;
  logic [15:0] addr;
  logic [7:0]  wdata, zd_in;
  logic        zwait_n, ziorqge;
  logic        busy, ack, claimed, err, zd_oe;
  logic        zmreq_n, ziorq_n, zrd_n, zwr_n;
  logic [7:0]  rdata, zd_out;
  logic [15:0] za;

  logic        eBusy, eAck, eZdOe, eMreqN, eIorqN, eRdN, eWrN, eClaimed, eErr;
  logic [15:0] eZa;
  logic [7:0]  eZdOut, eRdata;
  logic [15:0] mZa;
  logic [7:0]  mZdOut, mRdata;
  logic        mClaimed, mErr;

  bit chkEn = 1'b0;
  int nChecks = 0;
  int nFails = 0;
  int perCnt = 0;
  int lowCnt = 0;
  int ackAt = 0;

  always #5 clk = ~clk;

  zbus_master #(.T_CLKS(TC), .IO_WAIT(IOW), .WAIT_MAX(WMAX)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .we      (we),
    .io      (io),
    .addr    (addr),
    .wdata   (wdata),
    .busy    (busy),
    .ack     (ack),
    .rdata   (rdata),
    .claimed (claimed),
    .err     (err),
    .za      (za),
    .zd_out  (zd_out),
    .zd_oe   (zd_oe),
    .zd_in   (zd_in),
    .zmreq_n (zmreq_n),
    .ziorq_n (ziorq_n),
    .zrd_n   (zrd_n),
    .zwr_n   (zwr_n),
    .zwait_n (zwait_n),
    .ziorqge (ziorqge)
  );

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    perCnt++;
    if (!zmreq_n || !ziorq_n) lowCnt++;
    if (ack) ackAt = perCnt;
    if (chkEn) begin
      checkOutput("busy",    16'(busy),    16'(eBusy));
      checkOutput("ack",     16'(ack),     16'(eAck));
      checkOutput("za",      za,           eZa);
      checkOutput("zd_out",  16'(zd_out),  16'(eZdOut));
      checkOutput("zd_oe",   16'(zd_oe),   16'(eZdOe));
      checkOutput("zmreq_n", 16'(zmreq_n), 16'(eMreqN));
      checkOutput("ziorq_n", 16'(ziorq_n), 16'(eIorqN));
      checkOutput("zrd_n",   16'(zrd_n),   16'(eRdN));
      checkOutput("zwr_n",   16'(zwr_n),   16'(eWrN));
      checkOutput("rdata",   16'(rdata),   16'(eRdata));
      checkOutput("claimed", 16'(claimed), 16'(eClaimed));
      checkOutput("err",     16'(err),     16'(eErr));
    end
  end

  task automatic driveNoise();
    zwait_n = 1'($urandom);
    zd_in   = 8'($urandom);
    ziorqge = 1'($urandom);
  endtask

  task automatic setIdleExp();
    eBusy    = 1'b0;
    eAck     = 1'b0;
    eZa      = mZa;
    eZdOut   = mZdOut;
    eZdOe    = 1'b0;
    eMreqN   = 1'b1;
    eIorqN   = 1'b1;
    eRdN     = 1'b1;
    eWrN     = 1'b1;
    eRdata   = mRdata;
    eClaimed = mClaimed;
    eErr     = mErr;
  endtask

  task automatic resetDut(input int n);
    rst = 1'b1;
    repeat (n) begin
      req = 1'($urandom);
      driveNoise();
      @(posedge clk);
      mRdata   = 8'h00;
      mClaimed = 1'b0;
      mErr     = 1'b0;
      mZa      = 16'h0000;
      mZdOut   = 8'h00;
      setIdleExp();
      chkEn = 1'b1;
      @(negedge clk);
    end
    rst = 1'b0;
    req = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      req   = 1'b0;
      we    = 1'($urandom);
      io    = 1'($urandom);
      addr  = 16'($urandom);
      wdata = 8'($urandom);
      driveNoise();
      @(posedge clk);
      setIdleExp();
      chkEn = 1'b1;
      @(negedge clk);
    end
  endtask

  // Called just after a negedge; period 0 is the clock in which req is presented.
  // nLow: how many zwait_n samples (after automatic IO waits) are held low.
  // rstAt: if nonzero, reset is raised during that period and the cycle is abandoned.
  task automatic applyStimulus(input logic iWe, input logic iIo, input logic [15:0] iAddr,
                               input logic [7:0] iWdata, input logic [7:0] iRd, input logic iGe,
                               input int nLow, input int rstAt);
    int   autoW, extra, tw, winHi, L, k, j;
    logic errX, inWin;
    autoW = iIo ? IOW : 0;
    extra = (nLow < WMAX) ? nLow : WMAX;
    errX  = (nLow > WMAX);
    tw    = autoW + extra;
    winHi = (3 + tw) * TC;
    L     = winHi + 1;
    req = 1'b1; we = iWe; io = iIo; addr = iAddr; wdata = iWdata;
    driveNoise();
    perCnt = 0; lowCnt = 0; ackAt = 0;
    mZa = iAddr; mZdOut = iWdata;
    for (int i = 1; i <= L; i++) begin
      @(posedge clk);
      inWin  = (i > TC) && (i <= winHi);
      eBusy  = (i < L);
      eAck   = (i == L);
      eZa    = iAddr;
      eZdOut = iWdata;
      eZdOe  = iWe && (i < L);
      eMreqN = !(inWin && !iIo);
      eIorqN = !(inWin && iIo);
      eRdN   = !(inWin && !iWe);
      eWrN   = !(inWin && iWe);
      if (i == L) begin
        if (!iWe) mRdata = iRd;
        mClaimed = iIo && iGe;
        mErr     = errX;
      end
      eRdata   = mRdata;
      eClaimed = mClaimed;
      eErr     = mErr;
      chkEn    = 1'b1;
      @(negedge clk);
      req   = (i < L) ? 1'($urandom) : 1'b0;
      we    = 1'($urandom);
      io    = 1'($urandom);
      addr  = 16'($urandom);
      wdata = 8'($urandom);
      driveNoise();
      if ((i % TC == 0) && (i >= 2 * TC)) begin
        k = i / TC - 2;
        if (k >= autoW && k <= tw) begin
          j = k - autoW + 1;
          zwait_n = (j <= nLow) ? 1'b0 : 1'b1;
        end
      end
      if (i == winHi) begin
        zd_in   = iRd;
        ziorqge = iGe;
      end
      if (i == rstAt) begin
        rst = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r, nLow;
    rst = 1'b1; req = 1'b0; we = 1'b0; io = 1'b0; addr = '0; wdata = '0;
    driveNoise();
    resetDut(3);
    idleCycles(2);

    applyStimulus(1'b0, 1'b0, 16'h4000, 8'h00, 8'h5A, 1'b1, 0, 0);
    checkOutput("memrd_latency", 16'(ackAt), 16'd7);
    checkOutput("memrd_strobe_len", 16'(lowCnt), 16'd4);
    checkOutput("memrd_rdata", 16'(rdata), 16'h005A);
    checkOutput("memrd_claimed", 16'(claimed), 16'd0);
    idleCycles(1);

    applyStimulus(1'b1, 1'b1, 16'h00AB, 8'h3C, 8'h77, 1'b1, 0, 0);
    checkOutput("iowr_latency", 16'(ackAt), 16'd9);
    checkOutput("iowr_strobe_len", 16'(lowCnt), 16'd6);
    checkOutput("iowr_rdata_kept", 16'(rdata), 16'h005A);
    idleCycles(2);

    applyStimulus(1'b0, 1'b1, 16'h00FE, 8'h00, 8'h81, 1'b1, 0, 0);
    checkOutput("iord_claim_rdata", 16'(rdata), 16'h0081);
    checkOutput("iord_claimed", 16'(claimed), 16'd1);
    idleCycles(1);
    applyStimulus(1'b0, 1'b1, 16'h00FE, 8'h00, 8'h81, 1'b0, 0, 0);
    checkOutput("iord_unclaimed", 16'(claimed), 16'd0);
    checkOutput("iord_unclaimed_rdata", 16'(rdata), 16'h0081);
    idleCycles(1);

    applyStimulus(1'b1, 1'b0, 16'h8000, 8'hE1, 8'h00, 1'b0, 3, 0);
    checkOutput("wait3_strobe_len", 16'(lowCnt), 16'd10);
    checkOutput("wait3_err", 16'(err), 16'd0);
    idleCycles(1);
    applyStimulus(1'b1, 1'b0, 16'h8002, 8'h1E, 8'h00, 1'b0, 255, 0);
    checkOutput("stuck_err", 16'(err), 16'd1);
    checkOutput("stuck_latency", 16'(ackAt), 16'd13);

    applyStimulus(1'b0, 1'b0, 16'h1111, 8'h00, 8'h22, 1'b0, 0, 0);
    checkOutput("stuck_err_cleared", 16'(err), 16'd0);
    applyStimulus(1'b1, 1'b1, 16'h0033, 8'h44, 8'h00, 1'b0, 1, 0);
    applyStimulus(1'b1, 1'b0, 16'h5555, 8'h66, 8'h00, 1'b0, 0, 0);
    idleCycles(2);

    applyStimulus(1'b1, 1'b0, 16'h1234, 8'hA5, 8'h00, 1'b0, 255, 6);
    resetDut(2);
    checkOutput("rst_no_ack", 16'(ackAt), 16'd0);
    idleCycles(1);
    applyStimulus(1'b0, 1'b0, 16'h8001, 8'h00, 8'hC3, 1'b0, 0, 0);
    checkOutput("after_rst_latency", 16'(ackAt), 16'd7);
    checkOutput("after_rst_rdata", 16'(rdata), 16'h00C3);
    idleCycles(1);

    for (int t = 0; t < 150; t++) begin
      r = int'($urandom_range(0, 9));
      if (r < 5)      nLow = 0;
      else if (r < 8) nLow = int'($urandom_range(1, 3));
      else            nLow = int'($urandom_range(3, 6));
      applyStimulus(1'($urandom), 1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
                    1'($urandom), nLow, 0);
      idleCycles(int'($urandom_range(0, 2)));
    end

    chkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
